// File: rtl/mdio_register_bank.sv
// Bus-facing register bank for an MDIO engine: a command FIFO toward the engine,
// a receive FIFO of read results, sticky overflow flags, channel select and interrupt.
module mdio_register_bank #(
    parameter int NUM_CH    = 1,
    parameter int CMD_DEPTH = 4,
    parameter int RX_DEPTH  = 4,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      addr,
    input  logic            write_en,
    input  logic            read_en,
    input  logic [31:0]     data_in,
    output logic [31:0]     data_out,
    output logic            read_valid,
    output logic [31:0]     tx_data,
    output logic [CH_W-1:0] tx_chan,
    output logic            tx_valid,
    input  logic            tx_ready,
    input  logic [15:0]     rx_data,
    input  logic            rx_valid,
    input  logic            engine_busy,
    output logic            irq
);

    localparam int CI_W = $clog2(CMD_DEPTH);
    localparam int CP_W = CI_W + 1;
    localparam int RI_W = $clog2(RX_DEPTH);
    localparam int RP_W = RI_W + 1;

    logic [CH_W+31:0] cmd_mem [CMD_DEPTH];
    logic [15:0]      rx_mem  [RX_DEPTH];

    logic [CP_W-1:0] cmd_wr_ptr, cmd_rd_ptr, cmd_level;
    logic [RP_W-1:0] rx_wr_ptr, rx_rd_ptr, rx_level;
    logic            cmd_full, rx_full, rx_nonempty;
    logic            cmd_ovf, rx_ovf;
    logic            irq_rx_en, irq_err_en;
    logic [CH_W-1:0] ctrl_chan, chan_wr, chan_sat;

    logic wr_cmd, wr_stat, wr_ctrl, rd_rx;
    logic cmd_push, cmd_pop, rx_push, rx_pop;
    logic [31:0] status_word, ctrl_word, rx_word, rd_word;

    assign cmd_level   = cmd_wr_ptr - cmd_rd_ptr;
    assign rx_level    = rx_wr_ptr - rx_rd_ptr;
    assign cmd_full    = (cmd_level == CP_W'(CMD_DEPTH));
    assign rx_full     = (rx_level == RP_W'(RX_DEPTH));
    assign rx_nonempty = (rx_level != '0);

    assign tx_valid             = (cmd_level != '0);
    assign {tx_chan, tx_data}   = cmd_mem[cmd_rd_ptr[CI_W-1:0]];

    assign wr_cmd  = write_en && (addr == 2'd0);
    assign wr_stat = write_en && (addr == 2'd1);
    assign wr_ctrl = write_en && (addr == 2'd2);
    assign rd_rx   = read_en  && (addr == 2'd0);

    // Full/empty decisions use the level at cycle start, so a push into a full
    // FIFO is dropped even when a pop happens in the same cycle.
    assign cmd_push = wr_cmd && !cmd_full;
    assign cmd_pop  = tx_valid && tx_ready;
    assign rx_push  = rx_valid && !rx_full;
    assign rx_pop   = rd_rx && rx_nonempty;

    assign chan_wr  = data_in[8 +: CH_W];
    assign chan_sat = (32'(chan_wr) > 32'(NUM_CH - 1)) ? CH_W'(NUM_CH - 1) : chan_wr;

    always_comb begin
        status_word             = '0;
        status_word[0]          = !cmd_full;
        status_word[1]          = rx_nonempty;
        status_word[2]          = engine_busy | tx_valid;
        status_word[3]          = cmd_ovf;
        status_word[4]          = rx_ovf;
        status_word[8 +: CP_W]  = cmd_level;
        status_word[16 +: RP_W] = rx_level;

        ctrl_word               = '0;
        ctrl_word[0]            = irq_rx_en;
        ctrl_word[1]            = irq_err_en;
        ctrl_word[8 +: CH_W]    = ctrl_chan;

        rx_word = rx_nonempty ? {1'b1, 15'b0, rx_mem[rx_rd_ptr[RI_W-1:0]]} : 32'h0;

        case (addr)
            2'd0:    rd_word = rx_word;
            2'd1:    rd_word = status_word;
            2'd2:    rd_word = ctrl_word;
            default: rd_word = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (cmd_push) cmd_mem[cmd_wr_ptr[CI_W-1:0]] <= {ctrl_chan, data_in};
        if (rx_push)  rx_mem[rx_wr_ptr[RI_W-1:0]]   <= rx_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_wr_ptr <= '0;
            cmd_rd_ptr <= '0;
            rx_wr_ptr  <= '0;
            rx_rd_ptr  <= '0;
            cmd_ovf    <= 1'b0;
            rx_ovf     <= 1'b0;
            irq_rx_en  <= 1'b0;
            irq_err_en <= 1'b0;
            ctrl_chan  <= '0;
            data_out   <= '0;
            read_valid <= 1'b0;
            irq        <= 1'b0;
        end else begin
            if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + 1'b1;
            if (cmd_pop)  cmd_rd_ptr <= cmd_rd_ptr + 1'b1;
            if (rx_push)  rx_wr_ptr  <= rx_wr_ptr + 1'b1;
            if (rx_pop)   rx_rd_ptr  <= rx_rd_ptr + 1'b1;

            // A new overflow wins over a same-cycle write-1-to-clear.
            if (wr_cmd && cmd_full)
                cmd_ovf <= 1'b1;
            else if (wr_stat && data_in[3])
                cmd_ovf <= 1'b0;

            if (rx_valid && rx_full)
                rx_ovf <= 1'b1;
            else if (wr_stat && data_in[4])
                rx_ovf <= 1'b0;

            if (wr_ctrl) begin
                irq_rx_en  <= data_in[0];
                irq_err_en <= data_in[1];
                ctrl_chan  <= chan_sat;
            end

            read_valid <= read_en;
            if (read_en) data_out <= rd_word;

            irq <= (irq_rx_en & rx_nonempty) | (irq_err_en & (cmd_ovf | rx_ovf));
        end
    end

endmodule
